spc_sweep_ctrl: RTL and testbench

//  Sequencer for the serial SPC configuration chain. Takes a 33-bit base config word and sweeps F<3:0>
//  (and optionally IQ) across a range; for each point it clears the chain, shifts the word in LSB first,

---
 rtl/spc_sweep_ctrl_if.sv | 32 +++
 rtl/spc_sweep_ctrl.sv | 136 +++++++++++++
 tb/tb_spc_sweep_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spc_sweep_ctrl_if.sv
// Board-side control/status bundle for the SPC sweep sequencer.
// The board logic drives the request and configuration fields; the sequencer drives the status and serial lines.
interface spc_sweep_ctrl_if #(
  parameter int unsigned WORD_W  = 33,
  parameter int unsigned DWELL_W = 16
);
  logic               Start;
  logic               Stop;
  logic [WORD_W-1:0]  Base_cfg;
  logic [3:0]         F_first;
  logic [3:0]         F_last;
  logic               Iq_both;
  logic [DWELL_W-1:0] Dwell;
  logic               Spc_cfg_out;
  logic               Spc_resetn;
  logic               Busy;
  logic               Meas_valid;
  logic               Done;
  logic [3:0]         Cur_F;
  logic               Cur_IQ;
  logic [5:0]         Point_idx;

  modport master (
    output Start, Stop, Base_cfg, F_first, F_last, Iq_both, Dwell,
    input  Spc_cfg_out, Spc_resetn, Busy, Meas_valid, Done, Cur_F, Cur_IQ, Point_idx
  );

  modport slave (
    input  Start, Stop, Base_cfg, F_first, F_last, Iq_both, Dwell,
    output Spc_cfg_out, Spc_resetn, Busy, Meas_valid, Done, Cur_F, Cur_IQ, Point_idx
  );
endinterface

// File: rtl/spc_sweep_ctrl.sv
// Sweeps F (and optionally IQ) of a base SPC config word. For each point it clears the chain,
// shifts the word in LSB first, then dwells with Meas_valid high.
module spc_sweep_ctrl #(
  parameter int unsigned WORD_W  = 33,
  parameter int unsigned DWELL_W = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  spc_sweep_ctrl_if.slave bus
);
  localparam int unsigned       BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_SHIFT, S_DWELL, S_NEXT, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WORD_W-1:0]  r_base, w_base_nxt, w_word;
  logic [3:0]         r_f_last, w_f_last_nxt, r_cur_f, w_cur_f_nxt;
  logic               r_iq_both, w_iq_both_nxt, r_cur_iq, w_cur_iq_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt, r_dw_cnt, w_dw_cnt_nxt, w_dwell_eff;
  logic [BIT_W-1:0]   r_bit, w_bit_nxt;
  logic [5:0]         r_idx, w_idx_nxt;
  logic               r_cfg_out, r_resetn, r_busy, r_meas, r_done;

  assign w_word      = {r_base[WORD_W-1:14], r_cur_f, r_cur_iq, r_base[8:0]};
  assign w_dwell_eff = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;

  always_comb begin
    w_state_nxt   = r_state;
    w_base_nxt    = r_base;
    w_f_last_nxt  = r_f_last;
    w_iq_both_nxt = r_iq_both;
    w_dwell_nxt   = r_dwell;
    w_cur_f_nxt   = r_cur_f;
    w_cur_iq_nxt  = r_cur_iq;
    w_idx_nxt     = r_idx;
    w_bit_nxt     = r_bit;
    w_dw_cnt_nxt  = r_dw_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.Start && !bus.Stop) begin
          w_base_nxt    = bus.Base_cfg;
          w_f_last_nxt  = bus.F_last;
          w_iq_both_nxt = bus.Iq_both;
          w_dwell_nxt   = bus.Dwell;
          w_cur_f_nxt   = bus.F_first;
          w_cur_iq_nxt  = 1'b0;
          w_idx_nxt     = '0;
          w_state_nxt   = S_CLR;
        end
      end
      S_CLR: begin
        w_bit_nxt   = '0;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_bit == LAST_BIT) begin
          w_dw_cnt_nxt = DWELL_W'(1);
          w_state_nxt  = S_DWELL;
        end else begin
          w_bit_nxt = r_bit + 1'b1;
        end
      end
      S_DWELL: begin
        if (r_dw_cnt >= w_dwell_eff) w_state_nxt = S_NEXT;
        else                         w_dw_cnt_nxt = r_dw_cnt + 1'b1;
      end
      S_NEXT: begin
        if (r_iq_both && !r_cur_iq) begin
          w_cur_iq_nxt = 1'b1;
          w_idx_nxt    = r_idx + 1'b1;
          w_state_nxt  = S_CLR;
        end else if (r_cur_f == r_f_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cur_f_nxt  = r_cur_f + 1'b1;
          w_cur_iq_nxt = 1'b0;
          w_idx_nxt    = r_idx + 1'b1;
          w_state_nxt  = S_CLR;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.Stop && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  // Outputs are registered from the next state so each one lines up with the state it describes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_f_last  <= '0;
      r_iq_both <= 1'b0;
      r_dwell   <= '0;
      r_cur_f   <= '0;
      r_cur_iq  <= 1'b0;
      r_idx     <= '0;
      r_bit     <= '0;
      r_dw_cnt  <= '0;
      r_cfg_out <= 1'b0;
      r_resetn  <= 1'b1;
      r_busy    <= 1'b0;
      r_meas    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_base    <= w_base_nxt;
      r_f_last  <= w_f_last_nxt;
      r_iq_both <= w_iq_both_nxt;
      r_dwell   <= w_dwell_nxt;
      r_cur_f   <= w_cur_f_nxt;
      r_cur_iq  <= w_cur_iq_nxt;
      r_idx     <= w_idx_nxt;
      r_bit     <= w_bit_nxt;
      r_dw_cnt  <= w_dw_cnt_nxt;
      r_cfg_out <= (w_state_nxt == S_SHIFT) ? w_word[w_bit_nxt] : 1'b0;
      r_resetn  <= (w_state_nxt != S_CLR);
      r_busy    <= (w_state_nxt == S_CLR) || (w_state_nxt == S_SHIFT) ||
                   (w_state_nxt == S_DWELL) || (w_state_nxt == S_NEXT);
      r_meas    <= (w_state_nxt == S_DWELL);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.Spc_cfg_out = r_cfg_out;
  assign bus.Spc_resetn  = r_resetn;
  assign bus.Busy        = r_busy;
  assign bus.Meas_valid  = r_meas;
  assign bus.Done        = r_done;
  assign bus.Cur_F       = r_cur_f;
  assign bus.Cur_IQ      = r_cur_iq;
  assign bus.Point_idx   = r_idx;
endmodule

// File: tb/tb_spc_sweep_ctrl.sv
// Self-checking bench for spc_sweep_ctrl: per-point expectations are built from the sweep rules
// (point list, word substitution, cycle budget per phase) and compared cycle by cycle.
module tb_spc_sweep_ctrl;
  localparam int unsigned WORD_W  = 33;
  localparam int unsigned DWELL_W = 16;

  logic Clk = 1'b0;
  logic Reset;
  int unsigned total = 0;
  int unsigned bad   = 0;

  spc_sweep_ctrl_if #(.WORD_W(WORD_W), .DWELL_W(DWELL_W)) bus ();

  spc_sweep_ctrl #(.WORD_W(WORD_W), .DWELL_W(DWELL_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic scramble_inputs(input bit with_start);
    bus.Base_cfg = WORD_W'({$urandom(), $urandom()});
    bus.F_first  = 4'($urandom());
    bus.F_last   = 4'($urandom());
    bus.Iq_both  = 1'($urandom());
    bus.Dwell    = DWELL_W'($urandom());
    bus.Start    = with_start ? 1'($urandom()) : 1'b0;
  endtask

  // Runs one whole sweep from a Start pulse; noise toggles Start and config inputs while busy.
  task automatic test_sweep(input string name, input logic [WORD_W-1:0] base, input logic [3:0] ff,
                            input logic [3:0] fl, input logic iqb, input logic [DWELL_W-1:0] dw,
                            input bit noise);
    int unsigned nf, np, deff, ctl_err, mv;
    logic [3:0] ef;
    logic eq;
    logic [WORD_W-1:0] w, cap;
    nf   = ((int'(fl) - int'(ff) + 16) % 16) + 1;
    np   = nf * (iqb ? 2 : 1);
    deff = (dw == 0) ? 1 : int'(dw);
    @(negedge Clk);
    bus.Base_cfg = base; bus.F_first = ff; bus.F_last = fl;
    bus.Iq_both = iqb; bus.Dwell = dw; bus.Stop = 1'b0; bus.Start = 1'b1;
    for (int p = 0; p < int'(np); p++) begin
      ef = 4'((int'(ff) + p / (iqb ? 2 : 1)) % 16);
      eq = iqb ? ((p % 2) == 1) : 1'b0;
      w = base;
      w[13:10] = ef;
      w[9] = eq;
      @(negedge Clk);
      total++;
      if ({bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Spc_cfg_out} !== 5'b01000) begin
        bad++;
        $display("FAIL %s clr_ctl p=%0d: got %b want 01000", name, p,
                 {bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Spc_cfg_out});
      end
      total++;
      if ({bus.Cur_F, bus.Cur_IQ, bus.Point_idx} !== {ef, eq, 6'(p)}) begin
        bad++;
        $display("FAIL %s point p=%0d: got F=%0d IQ=%0d idx=%0d want F=%0d IQ=%0d idx=%0d", name, p,
                 bus.Cur_F, bus.Cur_IQ, bus.Point_idx, ef, eq, p);
      end
      if (noise) scramble_inputs(1'b1);
      cap = '0;
      ctl_err = 0;
      for (int k = 0; k < int'(WORD_W); k++) begin
        @(negedge Clk);
        cap = {bus.Spc_cfg_out, cap[WORD_W-1:1]};
        if ({bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done} !== 4'b1100) ctl_err++;
        if (noise) scramble_inputs(1'b1);
      end
      total++;
      if (cap !== w) begin
        bad++;
        $display("FAIL %s word p=%0d: got %h want %h", name, p, cap, w);
      end
      total++;
      if (ctl_err != 0) begin
        bad++;
        $display("FAIL %s shift_ctl p=%0d: got %0d bad cycles want 0", name, p, ctl_err);
      end
      mv = 0;
      for (int k = 0; k < int'(deff); k++) begin
        @(negedge Clk);
        if ({bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Spc_cfg_out} === 5'b11100) mv++;
        if (noise) scramble_inputs(1'b1);
      end
      total++;
      if (mv != deff) begin
        bad++;
        $display("FAIL %s dwell p=%0d: got %0d valid cycles want %0d", name, p, mv, deff);
      end
      @(negedge Clk);
      total++;
      if ({bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Spc_cfg_out} !== 5'b11000) begin
        bad++;
        $display("FAIL %s next_ctl p=%0d: got %b want 11000", name, p,
                 {bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Spc_cfg_out});
      end
      if (noise) scramble_inputs(1'b1);
    end
    @(negedge Clk);
    bus.Start = 1'b0;
    total++;
    if ({bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Spc_cfg_out} !== 5'b10010) begin
      bad++;
      $display("FAIL %s done_ctl: got %b want 10010", name,
               {bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Spc_cfg_out});
    end
    total++;
    if ({bus.Cur_F, bus.Cur_IQ, bus.Point_idx} !== {fl, iqb, 6'(np - 1)}) begin
      bad++;
      $display("FAIL %s done_point: got F=%0d IQ=%0d idx=%0d want F=%0d IQ=%0d idx=%0d", name,
               bus.Cur_F, bus.Cur_IQ, bus.Point_idx, fl, iqb, np - 1);
    end
    @(negedge Clk);
    total++;
    if ({bus.Busy, bus.Done, bus.Spc_resetn} !== 3'b001) begin
      bad++;
      $display("FAIL %s idle_after: got %b want 001", name, {bus.Busy, bus.Done, bus.Spc_resetn});
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.Start = 1'b0; bus.Stop = 1'b0; bus.Base_cfg = '0; bus.F_first = '0;
    bus.F_last = '0; bus.Iq_both = 1'b0; bus.Dwell = '0;
    repeat (3) @(negedge Clk);
    total++;
    if ({bus.Spc_cfg_out, bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Cur_F, bus.Cur_IQ,
         bus.Point_idx} !== {5'b01000, 4'h0, 1'b0, 6'h0}) begin
      bad++;
      $display("FAIL reset_state: got cfg=%b rn=%b busy=%b mv=%b done=%b F=%0d IQ=%0d idx=%0d",
               bus.Spc_cfg_out, bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Cur_F,
               bus.Cur_IQ, bus.Point_idx);
    end
    Reset = 1'b0;
    @(negedge Clk);
    total++;
    if ({bus.Busy, bus.Done, bus.Spc_resetn} !== 3'b001) begin
      bad++;
      $display("FAIL reset_release: got %b want 001", {bus.Busy, bus.Done, bus.Spc_resetn});
    end
  endtask

  task automatic test_stop();
    int unsigned target, done_seen;
    // F 3..7, IQ off, Dwell 2 -> 37 cycles per point; bit 10 of point 2
    target = 1 + 2 * 37 + 1 + 10;
    @(negedge Clk);
    bus.Base_cfg = WORD_W'({$urandom(), $urandom()}); bus.F_first = 4'd3; bus.F_last = 4'd7;
    bus.Iq_both = 1'b0; bus.Dwell = 16'd2; bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (target - 1) @(negedge Clk);
    total++;
    if ({bus.Point_idx, bus.Cur_F, bus.Busy} !== {6'd2, 4'd5, 1'b1}) begin
      bad++;
      $display("FAIL stop_position: got idx=%0d F=%0d busy=%b want idx=2 F=5 busy=1",
               bus.Point_idx, bus.Cur_F, bus.Busy);
    end
    bus.Stop = 1'b1;
    @(negedge Clk);
    bus.Stop = 1'b0;
    total++;
    if ({bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Spc_cfg_out} !== 5'b10000) begin
      bad++;
      $display("FAIL stop_idle: got %b want 10000",
               {bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Spc_cfg_out});
    end
    done_seen = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("FAIL stop_quiet: got %0d active cycles want 0", done_seen);
    end
    test_sweep("stop_restart", WORD_W'(33'h1_2345_6789), 4'd3, 4'd7, 1'b0, 16'd2, 1'b0);
  endtask

  task automatic test_reset_mid();
    int unsigned target, act;
    // F 9..11, IQ both, Dwell 5 -> 40 cycles per point; third dwell cycle of point 1
    target = 1 + 40 + 1 + 33 + 2;
    @(negedge Clk);
    bus.Base_cfg = WORD_W'({$urandom(), $urandom()}); bus.F_first = 4'd9; bus.F_last = 4'd11;
    bus.Iq_both = 1'b1; bus.Dwell = 16'd5; bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (target - 1) @(negedge Clk);
    total++;
    if ({bus.Meas_valid, bus.Point_idx, bus.Cur_IQ} !== {1'b1, 6'd1, 1'b1}) begin
      bad++;
      $display("FAIL rmid_position: got mv=%b idx=%0d IQ=%b want mv=1 idx=1 IQ=1",
               bus.Meas_valid, bus.Point_idx, bus.Cur_IQ);
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    total++;
    if ({bus.Spc_cfg_out, bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Cur_F, bus.Cur_IQ,
         bus.Point_idx} !== {5'b01000, 4'h0, 1'b0, 6'h0}) begin
      bad++;
      $display("FAIL rmid_state: got cfg=%b rn=%b busy=%b mv=%b done=%b F=%0d IQ=%0d idx=%0d",
               bus.Spc_cfg_out, bus.Spc_resetn, bus.Busy, bus.Meas_valid, bus.Done, bus.Cur_F,
               bus.Cur_IQ, bus.Point_idx);
    end
    act = 0;
    repeat (50) begin
      @(negedge Clk);
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) act++;
    end
    total++;
    if (act != 0) begin
      bad++;
      $display("FAIL rmid_quiet: got %0d active cycles want 0", act);
    end
  endtask

  task automatic test_start_stop_idle();
    int unsigned act;
    @(negedge Clk);
    bus.F_first = 4'd1; bus.F_last = 4'd2; bus.Start = 1'b1; bus.Stop = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0; bus.Stop = 1'b0;
    act = 0;
    repeat (5) begin
      if ({bus.Busy, bus.Spc_resetn, bus.Done} !== 3'b010) act++;
      @(negedge Clk);
    end
    total++;
    if (act != 0) begin
      bad++;
      $display("FAIL start_stop_idle: got %0d non-idle cycles want 0", act);
    end
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;
    test_reset();
    test_sweep("single_point", WORD_W'(33'h0_0000_0561), 4'd5, 4'd5, 1'b0, 16'd4, 1'b0);
    test_sweep("iq_sweep", WORD_W'(33'h1_F0F0_A5A5), 4'd2, 4'd4, 1'b1, 16'd0, 1'b0);
    test_sweep("wrap", WORD_W'(33'h0_DEAD_BEEF), 4'd14, 4'd1, 1'b0, 16'd1, 1'b0);
    test_sweep("full_range", WORD_W'(33'h1_FFFF_FFFF), 4'd7, 4'd6, 1'b0, 16'd0, 1'b0);
    test_stop();
    test_reset_mid();
    test_sweep("busy_start_ignored", WORD_W'(33'h0_1357_9BDF), 4'd14, 4'd1, 1'b1, 16'd3, 1'b1);
    test_start_stop_idle();
    for (int i = 0; i < 4; i++) begin
      test_sweep("random", WORD_W'({$urandom(), $urandom()}), 4'($urandom()), 4'($urandom()),
                 1'($urandom()), DWELL_W'($urandom_range(0, 6)), 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
